// File: rtl/clock_pkg.sv
// Purpose: shared widths, limits and FSM state encoding for the clock block.
package clock_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

endpackage

// File: rtl/clock_prescaler.sv
// Purpose: divides clk down to a one-second tick.
// Ports: clk, reset (sync, active-high), en (count enable), clr (force count
//        to 0, wins over en), tick (combinational, high on the last count
//        while enabled).
module clock_prescaler #(
  parameter int unsigned CLK_PER_SEC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/clock_multimode.sv
// Purpose: 24h time-of-day clock with load handshake, 12/24h display and alarm.
// Ports: clk/reset (sync, active-high); run pauses time; load_valid/load_ready
//        handshake writes load_h/m/s (load_err pulses on out-of-range);
//        alarm_h/alarm_m/alarm_arm/alarm_ack drive the sticky alarm_o;
//        hours_o/mins_o/secs_o registered time, disp_hours_o/pm_o
//        combinational display view, sec_pulse_o one pulse per second.
module clock_multimode
  import clock_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 4,
  parameter bit          ALARM_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mode_12h,
  input  logic              load_valid,
  input  logic [HOUR_W-1:0] load_h,
  input  logic [MIN_W-1:0]  load_m,
  input  logic [SEC_W-1:0]  load_s,
  output logic              load_ready,
  output logic              load_err,
  input  logic [HOUR_W-1:0] alarm_h,
  input  logic [MIN_W-1:0]  alarm_m,
  input  logic              alarm_arm,
  input  logic              alarm_ack,
  output logic [HOUR_W-1:0] hours_o,
  output logic [MIN_W-1:0]  mins_o,
  output logic [SEC_W-1:0]  secs_o,
  output logic [HOUR_W-1:0] disp_hours_o,
  output logic              pm_o,
  output logic              sec_pulse_o,
  output logic              alarm_o
);

  state_e            state_q, ret_q, state_nrm_c;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  mins_q, mins_d;
  logic [SEC_W-1:0]  secs_q, secs_d;
  logic              load_ready_q, load_err_q, sec_pulse_q, alarm_q;
  logic              tick, load_acc_c, load_ok_c, tick_adv_c, alarm_hit_c;

  assign load_acc_c = load_valid && load_ready_q;
  assign load_ok_c  = (load_h <= HOUR_W'(HOUR_MAX)) && (load_m <= MIN_W'(MIN_MAX)) &&
                      (load_s <= SEC_W'(SEC_MAX));
  // Any accepted load suppresses a coincident tick.
  assign tick_adv_c = tick && !load_acc_c;

  clock_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run && (state_q != ST_IDLE)),
    .clr   (load_acc_c && load_ok_c),
    .tick  (tick)
  );

  // Next time value: ripple carry seconds -> minutes -> hours, load overrides.
  always_comb begin
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    if (load_acc_c) begin
      if (load_ok_c) begin
        hours_d = load_h;
        mins_d  = load_m;
        secs_d  = load_s;
      end
    end else if (tick_adv_c) begin
      if (secs_q == SEC_W'(SEC_MAX)) begin
        secs_d = '0;
        if (mins_q == MIN_W'(MIN_MAX)) begin
          mins_d  = '0;
          hours_d = (hours_q == HOUR_W'(HOUR_MAX)) ? '0 : hours_q + 1'b1;
        end else begin
          mins_d = mins_q + 1'b1;
        end
      end else begin
        secs_d = secs_q + 1'b1;
      end
    end
  end

  // Only a tick can land on the alarm minute; out-of-range alarm values never match.
  assign alarm_hit_c = ALARM_EN && tick_adv_c && alarm_arm && (hours_d == alarm_h) &&
                       (mins_d == alarm_m) && (secs_d == '0);

  // Mode-following state, used directly and as the return state after LOAD.
  always_comb begin
    state_nrm_c = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_nrm_c = ST_RUN;
      ST_RUN:   if (!run) state_nrm_c = ST_PAUSE;
      ST_PAUSE: if (run) state_nrm_c = ST_RUN;
      ST_LOAD:  state_nrm_c = ret_q;
      default:  state_nrm_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      hours_q      <= '0;
      mins_q       <= '0;
      secs_q       <= '0;
      load_ready_q <= 1'b0;
      load_err_q   <= 1'b0;
      sec_pulse_q  <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      hours_q     <= hours_d;
      mins_q      <= mins_d;
      secs_q      <= secs_d;
      sec_pulse_q <= tick_adv_c;
      load_err_q  <= load_acc_c && !load_ok_c;
      if (load_acc_c) begin
        state_q      <= ST_LOAD;
        ret_q        <= state_nrm_c;
        load_ready_q <= 1'b0;
      end else begin
        state_q      <= state_nrm_c;
        load_ready_q <= 1'b1;
      end
      // Set has priority over ack / disarm.
      if (!ALARM_EN) begin
        alarm_q <= 1'b0;
      end else if (alarm_hit_c) begin
        alarm_q <= 1'b1;
      end else if (alarm_ack || !alarm_arm) begin
        alarm_q <= 1'b0;
      end
    end
  end

  // Display hour: 0 -> 12, 13..23 -> 1..11 in 12h mode.
  always_comb begin
    disp_hours_o = hours_q;
    pm_o         = 1'b0;
    if (mode_12h) begin
      pm_o = (hours_q >= HOUR_W'(12));
      if (hours_q == '0) begin
        disp_hours_o = HOUR_W'(12);
      end else if (hours_q > HOUR_W'(12)) begin
        disp_hours_o = hours_q - HOUR_W'(12);
      end
    end
  end

  assign hours_o     = hours_q;
  assign mins_o      = mins_q;
  assign secs_o      = secs_q;
  assign load_ready  = load_ready_q;
  assign load_err    = load_err_q;
  assign sec_pulse_o = sec_pulse_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_clock_multimode.sv
// Purpose: self-checking bench for clock_multimode at CLK_PER_SEC=4.
module tb_clock_multimode;

  logic       clk = 1'b0;
  logic       reset, run, mode_12h, load_valid;
  logic [4:0] load_h, alarm_h;
  logic [5:0] load_m, load_s, alarm_m;
  logic       alarm_arm, alarm_ack;
  logic       load_ready, load_err, pm_o, sec_pulse_o, alarm_o;
  logic [4:0] hours_o, disp_hours_o;
  logic [5:0] mins_o, secs_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] mdl_t = '0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  clock_multimode #(.CLK_PER_SEC(4), .ALARM_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
    .load_valid(load_valid), .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .load_ready(load_ready), .load_err(load_err),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .hours_o(hours_o), .mins_o(mins_o), .secs_o(secs_o),
    .disp_hours_o(disp_hours_o), .pm_o(pm_o),
    .sec_pulse_o(sec_pulse_o), .alarm_o(alarm_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] now_t();
    return {hours_o, mins_o, secs_o};
  endfunction

  function automatic logic [16:0] adv(input logic [16:0] t);
    int h, m, s;
    h = int'(t[16:12]); m = int'(t[11:6]); s = int'(t[5:0]);
    s++;
    if (s == 60) begin
      s = 0; m++;
      if (m == 60) begin
        m = 0; h = (h + 1) % 24;
      end
    end
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle load request; checks the cycle right after the accepting edge.
  task automatic do_load(input int h, input int m, input int s);
    bit ok;
    ok = (h <= 23) && (m <= 59) && (s <= 59);
    load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    if (ok) mdl_t = {5'(h), 6'(m), 6'(s)};
    chk("load_err", 32'(load_err), 32'(!ok));
    chk("load_ready_lo", 32'(load_ready), 32'd0);
    chk("load_time", 32'(now_t()), 32'(mdl_t));
  endtask

  // Runs n seconds from prescaler phase 0; scoreboard gets one entry per second.
  task automatic run_secs(input int n);
    for (int i = 0; i < n; i++) begin
      mdl_t = adv(mdl_t);
      exp_q.push_back(mdl_t);
      step(3);
      chk("pulse_early", 32'(sec_pulse_o), 32'd0);
      step(1);
      chk("pulse_on_tick", 32'(sec_pulse_o), 32'd1);
    end
    chk("run_time", 32'(now_t()), 32'(mdl_t));
  endtask

  // Scoreboard consumer: every second pulse must match the next expected time.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (sec_pulse_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_time", 32'(now_t()), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load_valid = 1'b0;
    load_h = '0; load_m = '0; load_s = '0;
    alarm_h = '0; alarm_m = '0; alarm_arm = 1'b0; alarm_ack = 1'b0;

    // Reset state
    step(2);
    chk("rst_time", 32'(now_t()), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_alarm", 32'(alarm_o), 32'd0);
    chk("rst_pulse", 32'(sec_pulse_o), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    step(1);
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    chk("post_rst_time", 32'(now_t()), 32'd0);

    // Full rollover 23:59:58 -> 00:00:00
    run = 1'b1;
    step(1);
    do_load(23, 59, 58);
    run_secs(2);

    // Pause freezes time
    run = 1'b0;
    step(10);
    chk("pause_frozen", 32'(now_t()), 32'(mdl_t));

    // Out-of-range load
    do_load(24, 0, 0);
    step(1);
    chk("err_one_cycle", 32'(load_err), 32'd0);
    chk("ready_back", 32'(load_ready), 32'd1);

    // 12h / 24h display
    mode_12h = 1'b1;
    do_load(0, 30, 0);
    chk("disp_0", 32'(disp_hours_o), 32'd12);
    chk("pm_0", 32'(pm_o), 32'd0);
    step(1);
    do_load(12, 0, 0);
    chk("disp_12", 32'(disp_hours_o), 32'd12);
    chk("pm_12", 32'(pm_o), 32'd1);
    step(1);
    do_load(13, 5, 0);
    chk("disp_13", 32'(disp_hours_o), 32'd1);
    chk("pm_13", 32'(pm_o), 32'd1);
    mode_12h = 1'b0;
    #1;
    chk("disp_24h_13", 32'(disp_hours_o), 32'd13);
    chk("pm_24h", 32'(pm_o), 32'd0);
    step(1);

    // Alarm: set beats a held ack, then ack clears, loads never set
    alarm_h = 5'd7; alarm_m = 6'd0; alarm_arm = 1'b1; alarm_ack = 1'b1;
    do_load(6, 59, 59);
    run = 1'b1;
    run_secs(1);
    chk("alarm_set", 32'(alarm_o), 32'd1);
    run = 1'b0;
    step(1);
    chk("alarm_acked", 32'(alarm_o), 32'd0);
    alarm_ack = 1'b0;
    step(1);
    do_load(7, 0, 0);
    step(1);
    chk("alarm_no_load_set", 32'(alarm_o), 32'd0);

    // Load lands on the tick edge: load wins, no pulse
    do_load(10, 0, 0);
    run = 1'b1;
    step(3);
    do_load(5, 6, 7);
    chk("tick_load_nopulse", 32'(sec_pulse_o), 32'd0);
    run_secs(1);

    // Reset mid-count at 12:34:56 with alarm latched
    alarm_h = 5'd12; alarm_m = 6'd34;
    do_load(12, 33, 59);
    run_secs(1);
    chk("alarm_12_34", 32'(alarm_o), 32'd1);
    do_load(12, 34, 55);
    chk("alarm_sticky_load", 32'(alarm_o), 32'd1);
    run_secs(1);
    step(2);
    reset = 1'b1;
    step(1);
    chk("mid_rst_time", 32'(now_t()), 32'd0);
    chk("mid_rst_alarm", 32'(alarm_o), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd0);
    run = 1'b0;
    step(2);
    chk("hold_rst_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    step(1);
    chk("rel_rst_ready", 32'(load_ready), 32'd1);
    chk("rel_rst_time", 32'(now_t()), 32'd0);

    step(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
